// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag-index and width definitions for the execute-stage ALU
//
// Contents:
//   ALU_WIDTH  default datapath width
//   alu_op_e   4-bit opcode encoding (OP_ADD .. OP_ROR)
//   FLAG_*     bit positions inside the registered compare word
package alu_pkg;

   localparam int ALU_WIDTH = 16;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_NOR   = 4'd5,
      OP_NOT   = 4'd6,
      OP_SLL   = 4'd7,
      OP_SRL   = 4'd8,
      OP_SRA   = 4'd9,
      OP_SLT   = 4'd10,
      OP_SLTU  = 4'd11,
      OP_MUL   = 4'd12,
      OP_PASSB = 4'd13,
      OP_ROL   = 4'd14,
      OP_ROR   = 4'd15
   } alu_op_e;

   localparam int FLAG_EQ    = 0;
   localparam int FLAG_LT    = 1;
   localparam int FLAG_LTU   = 2;
   localparam int FLAG_ZERO  = 3;
   localparam int FLAG_NEG   = 4;
   localparam int FLAG_CARRY = 5;
   localparam int FLAG_OVF   = 6;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational shift/rotate unit for the ALU
//
// Ports:
//   op  opcode; only OP_SLL/OP_SRL/OP_SRA/OP_ROL/OP_ROR are meaningful
//   a   operand to shift or rotate
//   sh  shift/rotate amount (operand B bits 3:0)
//   y   shifted/rotated value (a unchanged for any other opcode)
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [3:0]       sh,
   output logic [WIDTH-1:0] y
);

   // Rotation is taken modulo WIDTH so narrow builds (WIDTH < 16) still
   // rotate rather than clear. A right shift by WIDTH yields zero, which
   // makes rot == 0 return a unchanged without a special case.
   int unsigned rot;

   always_comb begin
      rot = 32'(sh) % WIDTH;
      y   = a;
      case (op)
         OP_SLL:  y = a << sh;
         OP_SRL:  y = a >> sh;
         OP_SRA:  y = $signed(a) >>> sh;
         OP_ROL:  y = (a << rot) | (a >> (WIDTH - rot));
         OP_ROR:  y = (a >> rot) | (a << (WIDTH - rot));
         default: y = a;
      endcase
   end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered 16-bit execute-stage ALU with result and compare/flag outputs
//
// Build option: define ALU_MUL_EN to include the single-cycle multiplier for
// OP_MUL; without it OP_MUL returns zero and no multiplier is built.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset, clears result and compare
//   operation  opcode (alu_pkg::alu_op_e encoding)
//   readData1  operand A
//   readData2  operand B
//   result     registered function result, one cycle after the inputs
//   compare    registered flag word: EQ, LT, LTU, ZERO, NEG, CARRY, OVF in bits 0..6
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       operation,
   input  logic [WIDTH-1:0] readData1,
   input  logic [WIDTH-1:0] readData2,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] compare
);

   alu_op_e          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH-1:0] shift_y;
   logic             lt_s;
   logic             lt_u;
   logic             carry;
   logic             ovf;
   logic [WIDTH-1:0] next_result;
   logic [WIDTH-1:0] next_compare;

   assign op = alu_op_e'(operation);
   assign a  = readData1;
   assign b  = readData2;

   // One extra bit on each side: sum_ext[WIDTH] is the add carry-out,
   // diff_ext[WIDTH] is set when the subtraction borrows.
   assign sum_ext  = {1'b0, a} + {1'b0, b};
   assign diff_ext = {1'b0, a} - {1'b0, b};

   assign lt_s = $signed(a) < $signed(b);
   assign lt_u = a < b;

   alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .op (op),
      .a  (a),
      .sh (b[3:0]),
      .y  (shift_y)
   );

   always_comb begin
      next_result = '0;
      carry       = 1'b0;
      ovf         = 1'b0;
      case (op)
         OP_ADD: begin
            next_result = sum_ext[WIDTH-1:0];
            carry       = sum_ext[WIDTH];
            ovf         = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            next_result = diff_ext[WIDTH-1:0];
            carry       = ~diff_ext[WIDTH];
            ovf         = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:   next_result = a & b;
         OP_OR:    next_result = a | b;
         OP_XOR:   next_result = a ^ b;
         OP_NOR:   next_result = ~(a | b);
         OP_NOT:   next_result = ~a;
         OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR:
                   next_result = shift_y;
         OP_SLT:   next_result = {{(WIDTH-1){1'b0}}, lt_s};
         OP_SLTU:  next_result = {{(WIDTH-1){1'b0}}, lt_u};
`ifdef ALU_MUL_EN
         OP_MUL:   next_result = a * b;
`else
         OP_MUL:   next_result = '0;
`endif
         OP_PASSB: next_result = b;
         default:  next_result = '0;
      endcase

      // EQ/LT/LTU depend only on the operands; the rest track next_result.
      next_compare             = '0;
      next_compare[FLAG_EQ]    = (a == b);
      next_compare[FLAG_LT]    = lt_s;
      next_compare[FLAG_LTU]   = lt_u;
      next_compare[FLAG_ZERO]  = (next_result == '0);
      next_compare[FLAG_NEG]   = next_result[WIDTH-1];
      next_compare[FLAG_CARRY] = carry;
      next_compare[FLAG_OVF]   = ovf;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result  <= '0;
         compare <= '0;
      end else begin
         result  <= next_result;
         compare <= next_compare;
      end
   end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking directed bench for alu with an expected-value scoreboard
module tb_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  operation = 4'd0;
   logic [15:0] readData1 = 16'h0000;
   logic [15:0] readData2 = 16'h0000;
   logic [15:0] result;
   logic [15:0] compare;

   always #5 clk = ~clk;

   alu #(.WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .operation (operation),
      .readData1 (readData1),
      .readData2 (readData2),
      .result    (result),
      .compare   (compare)
   );

   logic [31:0] exp_q[$];
   string       tag_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   // Outputs are sampled on the falling edge, half a cycle after the
   // rising edge that captured the oldest outstanding vector.
   task automatic check_out();
      logic [31:0] e;
      string       t;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         vectors++;
         assert (result === e[31:16]) else begin
            miscompares++;
            $error("FAIL %s result: observed %h expected %h", t, result, e[31:16]);
         end
         assert (compare === e[15:0]) else begin
            miscompares++;
            $error("FAIL %s compare: observed %h expected %h", t, compare, e[15:0]);
         end
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [15:0] ec);
      @(negedge clk);
      check_out();
      reset     = rst;
      operation = op;
      readData1 = a;
      readData2 = b;
      exp_q.push_back({er, ec});
      tag_q.push_back(tag);
   endtask

   initial begin
      step("rst0",      1'b1, OP_ADD,   16'h0005, 16'h0005, 16'h0000, 16'h0000);
      step("rst1",      1'b1, OP_ADD,   16'h0005, 16'h0005, 16'h0000, 16'h0000);
      step("add_1_0",   1'b0, OP_ADD,   16'h0001, 16'h0000, 16'h0001, 16'h0000);
      step("add_1_3",   1'b0, OP_ADD,   16'h0001, 16'h0003, 16'h0004, 16'h0006);
      step("sub_eq",    1'b0, OP_SUB,   16'h0001, 16'h0001, 16'h0000, 16'h0029);
      step("sub_ovf",   1'b0, OP_SUB,   16'h8000, 16'h0001, 16'h7FFF, 16'h0062);
      step("and",       1'b0, OP_AND,   16'h0005, 16'h0006, 16'h0004, 16'h0006);
      step("or_eq",     1'b0, OP_OR,    16'h0002, 16'h0002, 16'h0002, 16'h0001);
      step("xor_zero",  1'b0, OP_XOR,   16'h0003, 16'h0003, 16'h0000, 16'h0009);
      step("slt",       1'b0, OP_SLT,   16'hFFFF, 16'h0001, 16'h0001, 16'h0002);
      step("sltu",      1'b0, OP_SLTU,  16'hFFFF, 16'h0001, 16'h0000, 16'h000A);
      step("sra15",     1'b0, OP_SRA,   16'h8000, 16'h000F, 16'hFFFF, 16'h0012);
      step("rol1",      1'b0, OP_ROL,   16'h8001, 16'h0001, 16'h0003, 16'h0002);
      step("add_wrap",  1'b0, OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 16'h002A);
      step("sll_hiB",   1'b0, OP_SLL,   16'h0001, 16'h0014, 16'h0010, 16'h0006);
      step("srl_hiB",   1'b0, OP_SRL,   16'h8000, 16'hFFF1, 16'h4000, 16'h0006);
      step("ror4",      1'b0, OP_ROR,   16'h0001, 16'h0004, 16'h1000, 16'h0006);
      step("rol0",      1'b0, OP_ROL,   16'h1234, 16'h0010, 16'h1234, 16'h0000);
      step("not",       1'b0, OP_NOT,   16'h00FF, 16'h00FF, 16'hFF00, 16'h0011);
      step("nor",       1'b0, OP_NOR,   16'h0F0F, 16'h00F0, 16'hF000, 16'h0010);
      step("passb",     1'b0, OP_PASSB, 16'h0000, 16'h8000, 16'h8000, 16'h0014);
      step("add_ovf",   1'b0, OP_ADD,   16'h7FFF, 16'h0001, 16'h8000, 16'h0050);
      step("mid_rst",   1'b1, OP_ADD,   16'h0002, 16'h0003, 16'h0000, 16'h0000);
      step("sub_after", 1'b0, OP_SUB,   16'h0003, 16'h0002, 16'h0001, 16'h0020);
`ifdef ALU_MUL_EN
      step("mul",       1'b0, OP_MUL,   16'h0003, 16'h0005, 16'h000F, 16'h0006);
`else
      step("mul",       1'b0, OP_MUL,   16'h0003, 16'h0005, 16'h0000, 16'h000E);
`endif
      step("sub_borrow",1'b0, OP_SUB,   16'h0000, 16'h0001, 16'hFFFF, 16'h0016);

      // Drain the last outstanding vector.
      @(negedge clk);
      check_out();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
